// File: rtl/cache_mem_arbiter.sv
// Shares one RAM port between icache and dcache fill/writeback traffic, with a grant-hold FSM and a watchdog.
// Optional round-robin between the two caches when CACHE_ARB_FAIR_EN is defined; strict dcache priority otherwise.
`timescale 1ns/1ps
module cache_mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        op_wr, op_wr_nxt;
  logic [31:0] addr_nxt, store_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        bus_err_nxt;
  logic        d_req, pick_d, grant, timeout;

  assign d_req   = dREN | dWEN;
  assign grant   = (state != IDLE);
  // A ready arriving in the same cycle the count expires still counts as a completion.
  assign timeout = grant && !ramready && (cnt == TO_CNT);

`ifdef CACHE_ARB_FAIR_EN
  logic last_d, last_d_nxt;

  assign pick_d = d_req && (!iREN || !last_d);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) last_d <= 1'b0;
    else       last_d <= last_d_nxt;
  end

  always_comb begin
    last_d_nxt = last_d;
    if (state == IDLE && (d_req || iREN)) last_d_nxt = pick_d;
  end
`else
  assign pick_d = d_req;
`endif

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      op_wr    <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      cnt      <= '0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_wr    <= op_wr_nxt;
      ramaddr  <= addr_nxt;
      ramstore <= store_nxt;
      cnt      <= cnt_nxt;
      bus_err  <= bus_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    op_wr_nxt   = op_wr;
    addr_nxt    = ramaddr;
    store_nxt   = ramstore;
    cnt_nxt     = cnt;
    bus_err_nxt = bus_err;
    case (state)
      IDLE: begin
        if (d_req || iREN) begin
          cnt_nxt = '0;
          if (pick_d) begin
            state_nxt = DGNT;
            addr_nxt  = daddr;
            store_nxt = dstore;
            op_wr_nxt = dWEN;
          end else begin
            state_nxt = IGNT;
            addr_nxt  = iaddr;
            op_wr_nxt = 1'b0;
          end
        end
      end
      default: begin
        if (ramready || timeout) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
        if (timeout) bus_err_nxt = 1'b1;
      end
    endcase
  end

  always_comb begin
    ramREN = (state == IGNT) || (state == DGNT && !op_wr);
    ramWEN = (state == DGNT) && op_wr;
    iwait  = 1'b1;
    dwait  = 1'b1;
    iload  = '0;
    dload  = '0;
    if (state == IGNT && (ramready || timeout)) begin
      iwait = 1'b0;
      if (ramready) iload = ramload;
    end
    if (state == DGNT && (ramready || timeout)) begin
      dwait = 1'b0;
      if (ramready) dload = ramload;
    end
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the instruction-cache and data-cache miss/writeback traffic onto the single shared RAM port. It sits between the icache/dcache fill logic and the memory controller. It latches the winning request, holds the grant until the RAM signals completion, and returns the load data and wait release to the granted requester only. A watchdog flags a RAM that never completes.

## Interface
Parameters:
- `TIMEOUT`, 255: cycles a granted access may wait for `ramready` before abort (1..65535).

Ports:
- `CLK`  in  1  system clock; all state on rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `iREN`  in  1  icache fill request; held until `iwait` low.
- `iaddr`  in  32  icache word address.
- `iload`  out  32  fill data to icache; valid when `iwait` low.
- `iwait`  out  1  low for exactly one cycle when the icache transaction completes.
- `dREN`  in  1  dcache read request; held until `dwait` low.
- `dWEN`  in  1  dcache write request; held until `dwait` low.
- `daddr`  in  32  dcache word address.
- `dstore`  in  32  dcache write data.
- `dload`  out  32  read data to dcache; valid when `dwait` low.
- `dwait`  out  1  low for exactly one cycle when the dcache transaction completes.
- `ramREN`  out  1  RAM read enable.
- `ramWEN`  out  1  RAM write enable.
- `ramaddr`  out  32  RAM address (registered).
- `ramstore`  out  32  RAM write data (registered).
- `ramload`  in  32  RAM read data; valid with `ramready`.
- `ramready`  in  1  one-cycle pulse: current access complete.
- `bus_err`  out  1  sticky; set on timeout, cleared only by reset.

## Operation
- States: IDLE, IGNT, DGNT.
- In IDLE, if any request is high, select a winner, latch its address, write data and op into `ramaddr`/`ramstore`/op register, and move to IGNT or DGNT.
- Strict priority by default: a dcache request (`dREN|dWEN`) beats `iREN`.
- If `dREN` and `dWEN` are both high, perform the write. `dREN` is ignored.
- In IGNT: `ramREN`=1, `ramWEN`=0.
- In DGNT: `ramWEN`=latched write op, `ramREN`=!latched write op.
- Enables are decoded from state and the op register, so they are glitch-free and registered in effect.
- On a `ramready` cycle in a grant state:
  - The granted side's wait goes low combinationally in that cycle.
  - Its load output equals `ramload` (`dload` for a write is don't-care, driven as `ramload`).
  - The state returns to IDLE next cycle.
- The non-granted side's wait stays 1 and its load output stays 0.
- A request deasserted mid-grant does not abort the access. The access completes and the wait pulse is still issued.
- `ramready` in IDLE is ignored.
- Watchdog:
  - A 16-bit counter clears on entry to a grant state and increments each grant cycle without `ramready`.
  - When the counter reaches `TIMEOUT`, set `bus_err`, pulse the granted wait low for one cycle with load=0, and return to IDLE.
- Reset (asynchronous, any state, including mid-grant):
  - State=IDLE, counter=0, `bus_err`=0.
  - `ramREN`=`ramWEN`=0, `ramaddr`=`ramstore`=0.
  - `iwait`=`dwait`=1, `iload`=`dload`=0.
  - The interrupted access is dropped and is not replayed.

## Timing
- Arbitration latency: a request first seen high in IDLE in cycle N drives RAM enables from cycle N+1.
- Completion: the wait goes low in the same cycle as `ramready`.
- Minimum transaction: 2 cycles (grant cycle with same-cycle `ramready`), plus 1 IDLE cycle before the next grant.
- Back-to-back throughput: one access per (RAM latency + 1) cycles.
- A requester must hold its request through the cycle its wait is low. Re-sampling happens only in IDLE, so a held request after completion starts a new transaction.

## Configuration
- `CACHE_ARB_FAIR_EN`:
  - When defined, a 1-bit last-grant register (reset 0 = last grant was I) is kept.
  - If both sides request in IDLE, the side not granted last wins, giving round-robin.
  - A lone requester always wins.
- Undefined: strict dcache priority. The icache can starve under continuous dcache traffic.

## Test plan
- Reset mid-DGNT (`dWEN`, daddr=0x100), assert `nRST`=0 -> same cycle `ramWEN`=0, `dwait`=1, `ramaddr`=0. After release, state is IDLE and no access is issued without a new request.
- Lone `iREN`, iaddr=0x40, RAM 3-cycle latency, ramload=0xDEADBEEF -> `ramREN`=1 with `ramaddr`=0x40 one cycle after the request. `iwait`=0 and `iload`=0xDEADBEEF in the `ramready` cycle. `dwait` stays 1.
- `iREN` and `dREN` raised together, both held -> D granted first. Without the macro, I is granted on the next IDLE only after `dREN` drops. With `CACHE_ARB_FAIR_EN`, I is granted next even while `dREN` stays high.
- `dREN`=`dWEN`=1, daddr=0x200, dstore=0x12345678 -> `ramWEN`=1, `ramREN`=0, `ramstore`=0x12345678, `dwait` low on `ramready`.
- `iREN` withdrawn one cycle into IGNT -> access still completes and the `iwait` pulse is still issued. Unrelated `ramready` pulses in IDLE -> no wait pulses.
- `TIMEOUT`=8, RAM never asserts `ramready` for a dREN -> `dwait` low with `dload`=0 after 8 grant cycles, then `bus_err`=1 stays set through later successful accesses.
